// File: rtl/chip_link_tx_arb_if.sv
// Flit-level link between the transmit arbiter and the remote receiver:
// 4-phase valid/ready with per-flit even parity and a receiver error flag.
interface chip_link_tx_arb_if #(
  parameter int FLIT_W = 16
) ();
  logic [FLIT_W-1:0] send_data_out;
  logic              send_data_valid;
  logic              send_data_par;
  logic              send_data_ready;
  logic              send_data_err;

  modport master (
    output send_data_out,
    output send_data_valid,
    output send_data_par,
    input  send_data_ready,
    input  send_data_err
  );

  modport slave (
    input  send_data_out,
    input  send_data_valid,
    input  send_data_par,
    output send_data_ready,
    output send_data_err
  );
endinterface

// File: rtl/chip_link_tx_arb.sv
// Round-robin packet scheduler for one inter-chip link port: serialises each packet
// MSB flit first over a 4-phase handshake and resends a flit on receiver parity error.
module chip_link_tx_arb #(
  parameter int NREQ      = 2,
  parameter int PW        = 64,
  parameter int FLIT_W    = 16,
  parameter int MAX_RETRY = 3,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*PW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  chip_link_tx_arb_if.master   link,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 retry_fail
);

  localparam int NFLIT = PW / FLIT_W;
  localparam int KW    = $clog2(NFLIT + 1);
  localparam int RW    = $clog2(MAX_RETRY + 1);
  localparam logic [KW-1:0] LAST_K    = KW'(NFLIT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t              state_r;
  logic [PW-1:0]       pkt_r;
  logic [KW-1:0]       k_r;
  logic [RW-1:0]       retry_r;
  logic [GW-1:0]       rr_r;
  logic                abort_r;
  logic [FLIT_W-1:0]   data_r;
  logic                valid_r;
  logic                par_r;

  logic                any_s;
  logic [GW-1:0]       win_s;
  logic [NREQ-1:0]     win_onehot_s;
  logic [PW-1:0]       win_data_s;
  logic [GW-1:0]       rr_next_s;
  logic [FLIT_W-1:0]   flit_s;

  function automatic logic even_par(input logic [FLIT_W-1:0] d);
    return ^d;
  endfunction

  // First requester at or above the pointer, wrapping past the top index.
  function automatic logic [GW-1:0] pick_winner(input logic [NREQ-1:0] v,
                                                input logic [GW-1:0]   rr);
    logic [GW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr) + i) % NREQ;
      if (!found && v[idx]) begin
        w     = GW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // The packet register shifts left as flits complete, so the current flit is always on top.
  assign flit_s = pkt_r[PW-1 -: FLIT_W];

  assign link.send_data_out   = data_r;
  assign link.send_data_valid = valid_r;
  assign link.send_data_par   = par_r;

  // Arbitration winner, its packet, and the pointer value that follows it.
  always_comb begin
    any_s        = |req_valid;
    win_s        = pick_winner(req_valid, rr_r);
    win_onehot_s = '0;
    win_onehot_s[win_s] = 1'b1;
    win_data_s   = req_data[int'(win_s)*PW +: PW];
    if (int'(win_s) == NREQ - 1) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = win_s + GW'(1);
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pkt_r      <= '0;
      k_r        <= '0;
      retry_r    <= '0;
      rr_r       <= '0;
      abort_r    <= 1'b0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      par_r      <= 1'b0;
      req_ready  <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      retry_fail <= 1'b0;
    end else begin
      req_ready  <= '0;
      retry_fail <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            pkt_r     <= win_data_s;
            req_ready <= win_onehot_s;
            grant_id  <= win_s;
            rr_r      <= rr_next_s;
            k_r       <= '0;
            retry_r   <= '0;
            abort_r   <= 1'b0;
            busy      <= 1'b1;
            state_r   <= GAP;
          end
        end
        GAP: begin
          // Return-to-zero: nothing moves until the receiver drops ready.
          if (!link.send_data_ready) begin
            if (k_r == LAST_K || abort_r) begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              data_r  <= flit_s;
              par_r   <= even_par(flit_s);
              valid_r <= 1'b1;
              state_r <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (link.send_data_ready) begin
            valid_r <= 1'b0;
            state_r <= GAP;
            if (!link.send_data_err) begin
              k_r     <= k_r + KW'(1);
              retry_r <= '0;
              pkt_r   <= pkt_r << FLIT_W;
            end else if (retry_r < RETRY_MAX) begin
              retry_r <= retry_r + RW'(1);
            end else begin
              retry_fail <= 1'b1;
              abort_r    <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
